// File: rtl/hpdmc_dly_ctrl.sv
// Tap sequencer for NLANES IODELAY2 input delays (VARIABLE_FROM_ZERO).
// Owns CAL/RST/CE/INC pulsing, BUSY handshaking and per-lane tap tracking.
module hpdmc_dly_ctrl #(
    parameter int NLANES     = 2,
    parameter int TAP_W      = 8,
    parameter int TAP_MAX    = 255,
    parameter int BUSY_GUARD = 2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [NLANES-1:0]       cmd_mask,
    input  logic [TAP_W-1:0]        cmd_tap,
    output logic                    done,
    output logic [NLANES*TAP_W-1:0] tap,
    output logic                    dly_cal,
    output logic                    dly_rst,
    output logic [NLANES-1:0]       dly_ce,
    output logic [NLANES-1:0]       dly_inc,
    input  logic [NLANES-1:0]       dly_busy
);
    localparam int GW = (BUSY_GUARD < 1) ? 1 : $clog2(BUSY_GUARD + 1);
    localparam logic [GW-1:0]    GUARD = GW'(BUSY_GUARD);
    localparam logic [GW-1:0]    GONE  = GW'(1);
    localparam logic [TAP_W-1:0] TMAX  = TAP_W'(TAP_MAX);
    localparam logic [TAP_W-1:0] TONE  = TAP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAL,
        S_CALWAIT,
        S_RSTP,
        S_RSTWAIT,
        S_STEP,
        S_STEPWAIT
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                op_q, op_d;
    logic [NLANES-1:0]         mask_q, mask_d;
    logic [TAP_W-1:0]          ctap_q, ctap_d;
    logic [NLANES-1:0]         move_q, move_d;
    logic [GW-1:0]             cnt_q, cnt_d;
    logic [NLANES*TAP_W-1:0]   tap_q, tap_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      done_q, done_d;
    logic                      dly_cal_q, dly_cal_d;
    logic                      dly_rst_q, dly_rst_d;
    logic [NLANES-1:0]         dly_ce_q, dly_ce_d;
    logic [NLANES-1:0]         dly_inc_q, dly_inc_d;

    logic [TAP_W-1:0]          goal [NLANES];
    logic [NLANES-1:0]         step_mv;
    logic [NLANES-1:0]         step_up;

    // Per-lane goal for the latched op; only masked lanes off-goal move.
    always_comb begin
        for (int i = 0; i < NLANES; i++) begin
            goal[i] = tap_q[i*TAP_W +: TAP_W];
            unique case (op_q)
                2'b00: goal[i] = tap_q[i*TAP_W +: TAP_W];
                2'b01: goal[i] = (tap_q[i*TAP_W +: TAP_W] >= TMAX) ?
                                 TMAX : tap_q[i*TAP_W +: TAP_W] + TONE;
                2'b10: goal[i] = (tap_q[i*TAP_W +: TAP_W] == '0) ?
                                 '0 : tap_q[i*TAP_W +: TAP_W] - TONE;
                2'b11: goal[i] = (ctap_q > TMAX) ? TMAX : ctap_q;
            endcase
            step_mv[i] = mask_q[i] & (goal[i] != tap_q[i*TAP_W +: TAP_W]);
            step_up[i] = goal[i] > tap_q[i*TAP_W +: TAP_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mask_d    = mask_q;
        ctap_d    = ctap_q;
        move_d    = move_q;
        cnt_d     = cnt_q;
        tap_d     = tap_q;
        done_d    = 1'b0;
        dly_cal_d = 1'b0;
        dly_rst_d = 1'b0;
        dly_ce_d  = '0;
        dly_inc_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    mask_d  = cmd_mask;
                    ctap_d  = cmd_tap;
                    state_d = (cmd_op == 2'b00) ? S_CAL : S_STEP;
                end
            end
            S_CAL: begin
                dly_cal_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_CALWAIT;
            end
            S_CALWAIT: begin
                if (cnt_q < GUARD) begin
                    cnt_d = cnt_q + GONE;
                end else if ((dly_busy & mask_q) == '0) begin
                    state_d = S_RSTP;
                end
            end
            S_RSTP: begin
                // RST is shared by every lane, so all taps return to zero.
                dly_rst_d = 1'b1;
                tap_d     = '0;
                cnt_d     = '0;
                state_d   = S_RSTWAIT;
            end
            S_RSTWAIT: begin
                if (cnt_q < GUARD) begin
                    cnt_d = cnt_q + GONE;
                end else if ((dly_busy & mask_q) == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_STEP: begin
                if (step_mv == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    dly_ce_d  = step_mv;
                    dly_inc_d = step_mv & step_up;
                    move_d    = step_mv;
                    cnt_d     = '0;
                    state_d   = S_STEPWAIT;
                    for (int i = 0; i < NLANES; i++) begin
                        if (step_mv[i]) begin
                            tap_d[i*TAP_W +: TAP_W] = step_up[i] ?
                                tap_q[i*TAP_W +: TAP_W] + TONE :
                                tap_q[i*TAP_W +: TAP_W] - TONE;
                        end
                    end
                end
            end
            S_STEPWAIT: begin
                if (cnt_q < GUARD) begin
                    cnt_d = cnt_q + GONE;
                end else if ((dly_busy & move_q) == '0) begin
                    if (op_q == 2'b11) begin
                        state_d = S_STEP;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_CAL;
        endcase
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= S_CAL;
            op_q        <= '0;
            mask_q      <= '1;
            ctap_q      <= '0;
            move_q      <= '0;
            cnt_q       <= '0;
            tap_q       <= '0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            dly_cal_q   <= 1'b0;
            dly_rst_q   <= 1'b0;
            dly_ce_q    <= '0;
            dly_inc_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mask_q      <= mask_d;
            ctap_q      <= ctap_d;
            move_q      <= move_d;
            cnt_q       <= cnt_d;
            tap_q       <= tap_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            dly_cal_q   <= dly_cal_d;
            dly_rst_q   <= dly_rst_d;
            dly_ce_q    <= dly_ce_d;
            dly_inc_q   <= dly_inc_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign tap       = tap_q;
    assign dly_cal   = dly_cal_q;
    assign dly_rst   = dly_rst_q;
    assign dly_ce    = dly_ce_q;
    assign dly_inc   = dly_inc_q;

endmodule

// File: tb/tb_hpdmc_dly_ctrl.sv
// Scoreboard bench for hpdmc_dly_ctrl: a tap-level reference model queues
// the expected outcome of each command; a monitor checks it on done.
module tb_hpdmc_dly_ctrl;
    localparam int NL   = 2;
    localparam int TW   = 8;
    localparam int TMAX = 255;
    localparam int G    = 2;

    logic           clk = 1'b0;
    logic           sys_rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic [1:0]     cmd_op = '0;
    logic [NL-1:0]  cmd_mask = '0;
    logic [TW-1:0]  cmd_tap = '0;
    logic           cmd_ready;
    logic           done;
    logic [NL*TW-1:0] tap;
    logic           dly_cal;
    logic           dly_rst;
    logic [NL-1:0]  dly_ce;
    logic [NL-1:0]  dly_inc;
    logic [NL-1:0]  dly_busy = '0;

    always #5 clk = ~clk;

    hpdmc_dly_ctrl #(
        .NLANES(NL), .TAP_W(TW), .TAP_MAX(TMAX), .BUSY_GUARD(G)
    ) dut (
        .sys_clk(clk),
        .sys_rst(sys_rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_mask(cmd_mask),
        .cmd_tap(cmd_tap),
        .done(done),
        .tap(tap),
        .dly_cal(dly_cal),
        .dly_rst(dly_rst),
        .dly_ce(dly_ce),
        .dly_inc(dly_inc),
        .dly_busy(dly_busy)
    );

    typedef struct packed {
        int op;
        int cal;
        int rst;
        int lat;
        int min_lat;
        int gap;
        int acc;
        logic [NL-1:0][TW-1:0] taps;
        logic [NL-1:0][15:0]   ce;
        logic [NL-1:0]         up;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_len = 4;
    logic [NL-1:0] force_busy = '0;
    int ref_tap[NL];
    int bcnt[NL];
    int ce_cnt[NL];
    int inc_cnt[NL];
    int cal_cnt = 0, rst_cnt = 0, cal_cyc = 0, rst_cyc = 0;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // IODELAY2 BUSY: high for busy_len cycles after each CAL or CE.
    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (sys_rst) bcnt[i] = 0;
            else if (dly_cal || dly_ce[i]) bcnt[i] = busy_len;
            else if (bcnt[i] > 0) bcnt[i] = bcnt[i] - 1;
            dly_busy[i] = (bcnt[i] > 0) || force_busy[i];
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sys_rst) begin
            for (int i = 0; i < NL; i++) begin
                ce_cnt[i] = 0;
                inc_cnt[i] = 0;
            end
            cal_cnt = 0;
            rst_cnt = 0;
        end else begin
            if (dly_cal) begin cal_cnt++; cal_cyc = cyc; end
            if (dly_rst) begin rst_cnt++; rst_cyc = cyc; end
            for (int i = 0; i < NL; i++) begin
                if (dly_ce[i]) begin
                    ce_cnt[i]++;
                    if (dly_inc[i]) inc_cnt[i]++;
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    for (int i = 0; i < NL; i++) begin
                        chk($sformatf("tap%0d", i), int'(tap[i*TW +: TW]), int'(e.taps[i]));
                        chk($sformatf("ce_pulses%0d", i), ce_cnt[i], int'(e.ce[i]));
                        chk($sformatf("inc_pulses%0d", i), inc_cnt[i],
                            e.up[i] ? int'(e.ce[i]) : 0);
                        ce_cnt[i] = 0;
                        inc_cnt[i] = 0;
                    end
                    chk("cal_pulses", cal_cnt, e.cal);
                    chk("rst_pulses", rst_cnt, e.rst);
                    chk("ready_at_done", int'(cmd_ready), 1);
                    if (e.lat >= 0) chk("latency", cyc - e.acc, e.lat);
                    if (e.min_lat > 0)
                        chk("stall_latency_ok", int'((cyc - e.acc) >= e.min_lat), 1);
                    if (e.gap > 0)
                        chk("rst_after_busy", int'((rst_cyc - cal_cyc) >= e.gap), 1);
                    cal_cnt = 0;
                    rst_cnt = 0;
                end
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (cmd_ready !== 1'b1) begin
            @(negedge clk);
            k++;
            if (k > 6000) begin
                chk("ready_timeout", 0, 1);
                summary();
            end
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [NL-1:0] m,
                         input int t, input int min_lat);
        exp_t e;
        int g, d, n;
        bit clean;
        wait_ready();
        e = '0;
        n = 0;
        clean = (busy_len == 0) && (force_busy == '0);
        for (int i = 0; i < NL; i++) begin
            g = ref_tap[i];
            if (op == 2'b00) g = 0;
            else if (m[i]) begin
                if (op == 2'b01) g = (ref_tap[i] < TMAX) ? ref_tap[i] + 1 : TMAX;
                else if (op == 2'b10) g = (ref_tap[i] > 0) ? ref_tap[i] - 1 : 0;
                else g = (t > TMAX) ? TMAX : t;
            end
            d = (op == 2'b00) ? 0 : ((g > ref_tap[i]) ? g - ref_tap[i] : ref_tap[i] - g);
            e.ce[i] = 16'(d);
            e.up[i] = (op != 2'b00) && (g > ref_tap[i]);
            e.taps[i] = TW'(g);
            if (d > n) n = d;
            ref_tap[i] = g;
        end
        e.op = int'(op);
        e.lat = -1;
        if (op == 2'b00) begin
            e.cal = 1;
            e.rst = 1;
            if (clean) e.lat = 2 * G + 5;
            if (&m) e.gap = busy_len + 2;
        end else if (n == 0) e.lat = 2;
        else if (clean) e.lat = (op == 2'b11) ? n * (G + 2) + 2 : G + 3;
        e.min_lat = min_lat;
        e.acc = cyc;
        sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_mask = m;
        cmd_tap = TW'(t);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        exp_t e;
        sys_rst = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dly_cal", int'(dly_cal), 0);
        chk("rst_dly_rst", int'(dly_rst), 0);
        chk("rst_dly_ce", int'(dly_ce), 0);
        chk("rst_dly_inc", int'(dly_inc), 0);
        chk("rst_tap", int'(tap != '0), 0);
        sb.delete();
        e = '0;
        e.cal = 1;
        e.rst = 1;
        e.lat = -1;
        e.gap = busy_len + 2;
        for (int i = 0; i < NL; i++) ref_tap[i] = 0;
        sb.push_back(e);
        @(negedge clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        do_reset();
        issue(2'b11, 2'b01, 254, 0);
        issue(2'b01, 2'b01, 0, 0);
        issue(2'b01, 2'b01, 0, 0);
        issue(2'b00, 2'b11, 0, 0);
        issue(2'b10, 2'b11, 0, 0);
        issue(2'b11, 2'b01, 10, 0);
        issue(2'b11, 2'b10, 3, 0);
        issue(2'b11, 2'b11, 5, 0);
        wait_ready();
        busy_len = 0;
        issue(2'b01, 2'b11, 0, 0);
        issue(2'b11, 2'b11, 8, 0);
        issue(2'b00, 2'b11, 0, 0);
        wait_ready();
        busy_len = 4;
        force_busy = 2'b10;
        issue(2'b01, 2'b10, 0, 50);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("stall_ready_low", int'(cmd_ready), 0);
            chk("stall_no_done", int'(done), 0);
        end
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        cmd_mask = '1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            chk("stall_ready_low2", int'(cmd_ready), 0);
        end
        force_busy = '0;
        for (int n = 0; n < 40; n++) begin
            int op, t;
            logic [NL-1:0] m;
            wait_ready();
            busy_len = $urandom_range(0, 5);
            op = $urandom_range(0, 3);
            m = NL'($urandom);
            t = ($urandom_range(0, 9) == 0) ? $urandom_range(245, 255) : $urandom_range(0, 40);
            issue(op[1:0], m, t, 0);
        end
        wait_ready();
        busy_len = 4;
        issue(2'b11, 2'b11, 200, 0);
        repeat (30) @(negedge clk);
        do_reset();
        issue(2'b01, 2'b11, 0, 0);
        wait_ready();
        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        summary();
    end
endmodule
